// File: rtl/register_pipe_vr_pkg.sv
// Shared definitions for the valid/ready register pipe: occupancy counter
// width and the handshake transfer helper.
package register_pipe_vr_pkg;

    // Bits needed to count 0..depth valid stages.
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    // A word moves across an interface when both sides agree.
    function automatic logic xfer(input logic valid, input logic ready);
        return valid && ready;
    endfunction

endpackage

// File: rtl/register_pipe_vr_stage.sv
// One stage of the elastic pipe: a valid bit plus a data register that only
// loads when a real word arrives, so bubbles never toggle the data path.
module register_pipe_vr_stage #(
    parameter int               WIDTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_flush,
    input  logic             i_load,
    input  logic             i_up_valid,
    input  logic [WIDTH-1:0] i_up_data,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data
);

    logic             r_valid;
    logic [WIDTH-1:0] r_data;

    // Valid bit: flush clears it, otherwise it follows upstream when loading.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
        end else if (i_flush) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= i_up_valid;
        end else begin
            r_valid <= r_valid;
        end
    end

    // Data register: captures only real words; flush leaves it untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data <= RESET_VAL;
        end else if (!i_flush && i_load && i_up_valid) begin
            r_data <= i_up_data;
        end else begin
            r_data <= r_data;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

// File: rtl/register_pipe_vr.sv
// Elastic DEPTH-stage valid/ready pipeline register with synchronous flush
// and an occupancy count.
module register_pipe_vr
    import register_pipe_vr_pkg::*;
#(
    parameter int               WIDTH     = 4,
    parameter int               DEPTH     = 2,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic [cnt_w(DEPTH)-1:0]    count
);

    localparam int CW = cnt_w(DEPTH);

    logic [DEPTH-1:0] w_v;
    logic [WIDTH-1:0] w_d [DEPTH];
    logic [DEPTH:0]   w_rdy;
    logic             w_in_fire;
    logic             w_out_fire;
    logic [CW-1:0]    r_count;

    // Ready chain: a stage can load if it is empty or its successor moves.
    always_comb begin
        w_rdy        = {(DEPTH+1){1'b0}};
        w_rdy[DEPTH] = out_ready;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            w_rdy[i] = !w_v[i] || w_rdy[i+1];
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_stage
        if (g == 0) begin : g_head
            register_pipe_vr_stage #(
                .WIDTH     (WIDTH),
                .RESET_VAL (RESET_VAL)
            ) u_stage (
                .clk        (clk),
                .rst_n      (rst_n),
                .i_flush    (flush),
                .i_load     (w_rdy[g]),
                .i_up_valid (in_valid),
                .i_up_data  (in_data),
                .o_valid    (w_v[g]),
                .o_data     (w_d[g])
            );
        end else begin : g_body
            register_pipe_vr_stage #(
                .WIDTH     (WIDTH),
                .RESET_VAL (RESET_VAL)
            ) u_stage (
                .clk        (clk),
                .rst_n      (rst_n),
                .i_flush    (flush),
                .i_load     (w_rdy[g]),
                .i_up_valid (w_v[g-1]),
                .i_up_data  (w_d[g-1]),
                .o_valid    (w_v[g]),
                .o_data     (w_d[g])
            );
        end
    end

    assign in_ready   = w_rdy[0] && !flush;
    assign out_valid  = w_v[DEPTH-1];
    assign out_data   = w_d[DEPTH-1];
    assign w_in_fire  = xfer(in_valid, in_ready);
    assign w_out_fire = xfer(out_valid, out_ready);

    // Occupancy tracks entries minus exits; flush empties every stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= {CW{1'b0}};
        end else if (flush) begin
            r_count <= {CW{1'b0}};
        end else if (w_in_fire && !w_out_fire) begin
            r_count <= r_count + CW'(1);
        end else if (!w_in_fire && w_out_fire) begin
            r_count <= r_count - CW'(1);
        end else begin
            r_count <= r_count;
        end
    end

    assign count = r_count;

endmodule
